// File: rtl/display_pkg.sv
// Shared constants, segment patterns and conversion helpers for the
// four-digit seven-segment display driver.
package display_pkg;

  localparam int BIN_WIDTH  = 14;
  localparam int NUM_DIGITS = 4;
  localparam int BCD_WIDTH  = 4 * NUM_DIGITS;

  localparam logic [BIN_WIDTH-1:0] MAX_DISPLAY = 14'd9999;

  // Converter states kept as plain constants for compatibility with older tools
  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_SHIFT = 2'd1;
  localparam state_t ST_DONE  = 2'd2;

  // Segment order {g,f,e,d,c,b,a}, active-low
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_DIGITS [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  function automatic logic [BCD_WIDTH-1:0] dabble_adjust(input logic [BCD_WIDTH-1:0] bcd);
    logic [BCD_WIDTH-1:0] res;
    res = bcd;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5) begin
        res[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
      end else begin
        res[i*4 +: 4] = bcd[i*4 +: 4];
      end
    end
    return res;
  endfunction

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] seg;
    if (nib <= 4'd9) begin
      seg = SEG_DIGITS[nib];
    end else begin
      seg = SEG_BLANK;
    end
    return seg;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one shift per cycle, 14 iterations,
// with a start/busy/done handshake and the captured binary value exposed.
module bin2bcd_seq
  import display_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [BIN_WIDTH-1:0] bin_in,
  output logic                 busy,
  output logic                 done,
  output logic [BIN_WIDTH-1:0] value,
  output logic [BCD_WIDTH-1:0] bcd
);

  state_t                         state_r;
  state_t                         state_next_s;
  logic [BCD_WIDTH+BIN_WIDTH-1:0] shift_r;
  logic [BCD_WIDTH-1:0]           dabble_s;
  logic [3:0]                     count_r;
  logic [BIN_WIDTH-1:0]           value_r;
  logic                           busy_r;

  // Next-state decode and nibble correction for the current iteration
  always_comb begin
    state_next_s = state_r;
    dabble_s     = dabble_adjust(shift_r[BCD_WIDTH+BIN_WIDTH-1:BIN_WIDTH]);
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_next_s = ST_SHIFT;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (count_r == 4'd1) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_SHIFT;
        end
      end
      ST_DONE: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // State, shift register and iteration counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      shift_r <= '0;
      count_r <= 4'd0;
      value_r <= '0;
    end else begin
      state_r <= state_next_s;
      busy_r  <= (state_next_s != ST_IDLE);
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            shift_r <= {{BCD_WIDTH{1'b0}}, bin_in};
            count_r <= 4'd14;
            value_r <= bin_in;
          end
        end
        ST_SHIFT: begin
          shift_r <= {dabble_s, shift_r[BIN_WIDTH-1:0]} << 1'b1;
          count_r <= count_r - 4'd1;
        end
        default: begin
          count_r <= count_r;
        end
      endcase
    end
  end

  assign busy  = busy_r;
  assign done  = (state_r == ST_DONE);
  assign value = value_r;
  assign bcd   = shift_r[BCD_WIDTH+BIN_WIDTH-1:BIN_WIDTH];

endmodule

// File: rtl/bcd_display_driver.sv
// Four-digit multiplexed seven-segment driver: converts the selected binary
// number to BCD, blanks leading zeros, dashes out values above 9999.
module bcd_display_driver
  import display_pkg::*;
#(
  parameter int REFRESH_OVERFLOW = 2**19 - 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BIN_WIDTH-1:0] to_display_nr,
  output logic                 busy,
  output logic [3:0]           digit_select,
  output logic [6:0]           led_select
);

  localparam int CNT_W = (REFRESH_OVERFLOW > 0) ? $clog2(REFRESH_OVERFLOW + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(REFRESH_OVERFLOW);

  logic [BIN_WIDTH-1:0] last_value_r;
  logic [BCD_WIDTH-1:0] digit_r;
  logic                 overflow_r;
  logic [CNT_W-1:0]     refresh_cnt_r;
  logic [1:0]           index_r;
  logic [3:0]           digit_select_r;
  logic [6:0]           led_select_r;

  logic                 start_s;
  logic                 conv_busy_s;
  logic                 conv_done_s;
  logic [BIN_WIDTH-1:0] conv_value_s;
  logic [BCD_WIDTH-1:0] conv_bcd_s;
  logic [BCD_WIDTH-1:0] digit_next_s;
  logic                 overflow_next_s;
  logic [1:0]           index_next_s;
  logic [3:0]           nib_s;
  logic                 lead_zero_s;
  logic [6:0]           seg_s;

  assign start_s = !conv_busy_s && (to_display_nr != last_value_r);

  bin2bcd_seq u_bin2bcd (
    .clk    (clk),
    .reset  (reset),
    .start  (start_s),
    .bin_in (to_display_nr),
    .busy   (conv_busy_s),
    .done   (conv_done_s),
    .value  (conv_value_s),
    .bcd    (conv_bcd_s)
  );

  // Decode from next-cycle digit/index so the segment and anode registers
  // load together and a fresh result shows the cycle after DONE
  always_comb begin
    digit_next_s    = digit_r;
    overflow_next_s = overflow_r;
    index_next_s    = index_r;
    nib_s           = 4'd0;
    lead_zero_s     = 1'b0;
    seg_s           = SEG_BLANK;
    if (conv_done_s) begin
      digit_next_s    = conv_bcd_s;
      overflow_next_s = (conv_value_s > MAX_DISPLAY);
    end else begin
      digit_next_s    = digit_r;
      overflow_next_s = overflow_r;
    end
    if (refresh_cnt_r == CNT_TERM) begin
      index_next_s = index_r + 2'd1;
    end else begin
      index_next_s = index_r;
    end
    case (index_next_s)
      2'd0: begin
        nib_s       = digit_next_s[3:0];
        lead_zero_s = 1'b0;
      end
      2'd1: begin
        nib_s       = digit_next_s[7:4];
        lead_zero_s = (digit_next_s[15:4] == 12'd0);
      end
      2'd2: begin
        nib_s       = digit_next_s[11:8];
        lead_zero_s = (digit_next_s[15:8] == 8'd0);
      end
      2'd3: begin
        nib_s       = digit_next_s[15:12];
        lead_zero_s = (digit_next_s[15:12] == 4'd0);
      end
      default: begin
        nib_s       = 4'd0;
        lead_zero_s = 1'b1;
      end
    endcase
    if (overflow_next_s) begin
      seg_s = SEG_DASH;
    end else if (lead_zero_s) begin
      seg_s = SEG_BLANK;
    end else begin
      seg_s = seg_decode(nib_s);
    end
  end

  // Refresh counter, digit storage and registered pin outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      last_value_r   <= '0;
      digit_r        <= '0;
      overflow_r     <= 1'b0;
      refresh_cnt_r  <= '0;
      index_r        <= 2'd0;
      digit_select_r <= 4'b1110;
      led_select_r   <= 7'b1000000;
    end else begin
      if (refresh_cnt_r == CNT_TERM) begin
        refresh_cnt_r <= '0;
      end else begin
        refresh_cnt_r <= refresh_cnt_r + CNT_W'(1);
      end
      if (conv_done_s) begin
        last_value_r <= conv_value_s;
      end
      index_r        <= index_next_s;
      digit_r        <= digit_next_s;
      overflow_r     <= overflow_next_s;
      digit_select_r <= ~(4'b0001 << index_next_s);
      led_select_r   <= seg_s;
    end
  end

  assign busy         = conv_busy_s;
  assign digit_select = digit_select_r;
  assign led_select   = led_select_r;

endmodule
